// File: rtl/regfile_sb_if.sv
// Register-file/scoreboard bus: read ports, writeback port, reservation port and scoreboard status.
// Master is the issue/writeback side, slave is the register file; no handshake, stalls come from rd_busy/rsv_ok.
interface regfile_sb_if #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 5,
    parameter int N_RD     = 2
);
    logic [N_RD*ADDR_LEN-1:0] rd_addr;
    logic [N_RD*WORD_LEN-1:0] rd_data;
    logic [N_RD-1:0]          rd_busy;

    logic                     wen;
    logic [ADDR_LEN-1:0]      waddr;
    logic [WORD_LEN-1:0]      wdata;

    logic                     rsv_en;
    logic [ADDR_LEN-1:0]      rsv_addr;
    logic                     rsv_ok;
    logic                     rsv_err;
    logic [ADDR_LEN:0]        pend_cnt;

    modport master (
        output rd_addr, wen, waddr, wdata, rsv_en, rsv_addr,
        input  rd_data, rd_busy, rsv_ok, rsv_err, pend_cnt
    );

    modport slave (
        input  rd_addr, wen, waddr, wdata, rsv_en, rsv_addr,
        output rd_data, rd_busy, rsv_ok, rsv_err, pend_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register busy scoreboard; reads and rsv_ok are combinational, state updates next edge.
// No backpressure: the issue stage stalls on rd_busy and retries reservations that rsv_ok would reject.
module regfile_sb #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_LEN;

    logic [WORD_LEN-1:0] mem [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic                rsv_err_q;
    logic [ADDR_LEN:0]   pend_q;

    logic wr_eff;
    logic rsv_zero;
    logic wr_clears_rsv;
    logic rsv_ok_c;
    logic rsv_acc;
    logic cnt_inc;
    logic cnt_dec;

    // A same-cycle writeback to the reserved register frees it, so the new producer may claim it at once.
    always_comb begin
        wr_eff        = bus.wen && !((ZERO_REG != 0) && (bus.waddr == '0));
        rsv_zero      = (ZERO_REG != 0) && (bus.rsv_addr == '0);
        wr_clears_rsv = (BYPASS != 0) && wr_eff && (bus.waddr == bus.rsv_addr);
        rsv_ok_c      = rsv_zero || !busy[bus.rsv_addr] || wr_clears_rsv;
        rsv_acc       = bus.rsv_en && rsv_ok_c && !rsv_zero;
        cnt_inc       = rsv_acc && !busy[bus.rsv_addr];
        cnt_dec       = wr_eff && busy[bus.waddr] && !(rsv_acc && (bus.rsv_addr == bus.waddr));
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic                wr_hit;
        logic                rsv_hit;
        logic [WORD_LEN-1:0] q;
        logic                b;

        assign wr_hit  = wr_eff  && (bus.waddr    == ADDR_LEN'(g));
        assign rsv_hit = rsv_acc && (bus.rsv_addr == ADDR_LEN'(g));

        // Reservation beats the writeback clear: the newer producer owns the register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
                b <= 1'b0;
            end else begin
                if (wr_hit) begin
                    q <= bus.wdata;
                end
                if (rsv_hit) begin
                    b <= 1'b1;
                end else if (wr_hit) begin
                    b <= 1'b0;
                end
            end
        end

        assign mem[g]  = q;
        assign busy[g] = b;
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_LEN-1:0] a;
        logic                byp;
        logic [WORD_LEN-1:0] d;
        logic                bsy;

        assign a = bus.rd_addr[p*ADDR_LEN +: ADDR_LEN];

        // An accepted reservation on the same register keeps the stored view; it becomes busy next cycle.
        always_comb begin
            byp = (BYPASS != 0) && wr_eff && (bus.waddr == a)
                  && !(rsv_acc && (bus.rsv_addr == a));
            if ((ZERO_REG != 0) && (a == '0)) begin
                d   = '0;
                bsy = 1'b0;
            end else if (byp) begin
                d   = bus.wdata;
                bsy = 1'b0;
            end else begin
                d   = mem[a];
                bsy = busy[a];
            end
        end

        assign bus.rd_data[p*WORD_LEN +: WORD_LEN] = d;
        assign bus.rd_busy[p]                      = bsy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsv_err_q <= 1'b0;
            pend_q    <= '0;
        end else begin
            if (bus.rsv_en && !rsv_ok_c) begin
                rsv_err_q <= 1'b1;
            end
            if (cnt_inc && !cnt_dec) begin
                pend_q <= pend_q + (ADDR_LEN+1)'(1);
            end else if (cnt_dec && !cnt_inc) begin
                pend_q <= pend_q - (ADDR_LEN+1)'(1);
            end
        end
    end

    assign bus.rsv_ok   = rsv_ok_c;
    assign bus.rsv_err  = rsv_err_q;
    assign bus.pend_cnt = pend_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three configurations driven by directed and random steps, checked against a
// per-register array model of data, busy set and sticky error.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.WORD_LEN(32), .ADDR_LEN(5), .N_RD(2)) i0 ();
    regfile_sb_if #(.WORD_LEN(32), .ADDR_LEN(5), .N_RD(2)) i1 ();
    regfile_sb_if #(.WORD_LEN(8),  .ADDR_LEN(3), .N_RD(4)) i2 ();

    regfile_sb #(.WORD_LEN(32), .ADDR_LEN(5), .N_RD(2), .ZERO_REG(1), .BYPASS(1))
        u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    regfile_sb #(.WORD_LEN(32), .ADDR_LEN(5), .N_RD(2), .ZERO_REG(1), .BYPASS(0))
        u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    regfile_sb #(.WORD_LEN(8),  .ADDR_LEN(3), .N_RD(4), .ZERO_REG(0), .BYPASS(1))
        u2 (.clk(clk), .rst(rst), .bus(i2.slave));

    bit          zr    [3] = '{1'b1, 1'b1, 1'b0};
    bit          bp    [3] = '{1'b1, 1'b0, 1'b1};
    int          nrd   [3] = '{2, 2, 4};
    int          nregs [3] = '{32, 32, 8};
    logic [31:0] wmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

    logic [31:0] m_data [3][32];
    bit          m_busy [3][32];
    bit          m_err  [3];

    bit          cw, cre;
    int          cwa, cra;
    logic [31:0] cwd;
    int          crd [4];

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_err[k] = 1'b0;
            for (int r = 0; r < 32; r++) begin
                m_data[k][r] = '0;
                m_busy[k][r] = 1'b0;
            end
        end
    endtask

    function automatic bit m_ok(int k);
        if (zr[k] && cra == 0) return 1'b1;
        if (bp[k] && cw && cwa == cra) return 1'b1;
        return !m_busy[k][cra];
    endfunction

    function automatic bit m_acc(int k);
        return cre && m_ok(k) && !(zr[k] && cra == 0);
    endfunction

    task automatic m_read(input int k, input int a, output logic [31:0] d, output bit b);
        if (zr[k] && a == 0) begin
            d = '0; b = 1'b0;
        end else if (bp[k] && cw && cwa == a && !(m_acc(k) && cra == a)) begin
            d = cwd; b = 1'b0;
        end else begin
            d = m_data[k][a]; b = m_busy[k][a];
        end
    endtask

    function automatic int m_pend(int k);
        int n = 0;
        for (int r = 0; r < nregs[k]; r++) n += int'(m_busy[k][r]);
        return n;
    endfunction

    task automatic m_step(input int k);
        bit acc;
        acc = m_acc(k);
        if (cre && !m_ok(k)) m_err[k] = 1'b1;
        if (cw && !(zr[k] && cwa == 0)) begin
            m_data[k][cwa] = cwd;
            m_busy[k][cwa] = 1'b0;
        end
        if (acc) m_busy[k][cra] = 1'b1;
    endtask

    function automatic logic [31:0] o_data(int k, int p);
        case (k)
            0:       return i0.rd_data[p*32 +: 32];
            1:       return i1.rd_data[p*32 +: 32];
            default: return {24'h0, i2.rd_data[p*8 +: 8]};
        endcase
    endfunction

    function automatic logic [31:0] o_busy(int k, int p);
        case (k)
            0:       return {31'h0, i0.rd_busy[p]};
            1:       return {31'h0, i1.rd_busy[p]};
            default: return {31'h0, i2.rd_busy[p]};
        endcase
    endfunction

    function automatic logic [31:0] o_ok(int k);
        case (k)
            0:       return {31'h0, i0.rsv_ok};
            1:       return {31'h0, i1.rsv_ok};
            default: return {31'h0, i2.rsv_ok};
        endcase
    endfunction

    function automatic logic [31:0] o_err(int k);
        case (k)
            0:       return {31'h0, i0.rsv_err};
            1:       return {31'h0, i1.rsv_err};
            default: return {31'h0, i2.rsv_err};
        endcase
    endfunction

    function automatic logic [31:0] o_pend(int k);
        case (k)
            0:       return 32'(i0.pend_cnt);
            1:       return 32'(i1.pend_cnt);
            default: return 32'(i2.pend_cnt);
        endcase
    endfunction

    task automatic drive(input int k, input bit w, input int wa, input logic [31:0] wd,
                         input bit re, input int ra);
        case (k)
            0: begin
                i0.wen = w; i0.waddr = 5'(wa); i0.wdata = wd; i0.rsv_en = re; i0.rsv_addr = 5'(ra);
                for (int p = 0; p < 2; p++) i0.rd_addr[p*5 +: 5] = 5'(crd[p]);
            end
            1: begin
                i1.wen = w; i1.waddr = 5'(wa); i1.wdata = wd; i1.rsv_en = re; i1.rsv_addr = 5'(ra);
                for (int p = 0; p < 2; p++) i1.rd_addr[p*5 +: 5] = 5'(crd[p]);
            end
            default: begin
                i2.wen = w; i2.waddr = 3'(wa); i2.wdata = 8'(wd); i2.rsv_en = re; i2.rsv_addr = 3'(ra);
                for (int p = 0; p < 4; p++) i2.rd_addr[p*3 +: 3] = 3'(crd[p]);
            end
        endcase
    endtask

    task automatic check_now(input int k, input string tag);
        logic [31:0] d;
        bit          b;
        for (int p = 0; p < nrd[k]; p++) begin
            m_read(k, crd[p], d, b);
            chk($sformatf("%s u%0d rd%0d data", tag, k, p), o_data(k, p), d);
            chk($sformatf("%s u%0d rd%0d busy", tag, k, p), o_busy(k, p), {31'h0, b});
        end
        chk($sformatf("%s u%0d rsv_ok", tag, k), o_ok(k), {31'h0, m_ok(k)});
        chk($sformatf("%s u%0d rsv_err", tag, k), o_err(k), {31'h0, m_err[k]});
        chk($sformatf("%s u%0d pend_cnt", tag, k), o_pend(k), 32'(m_pend(k)));
    endtask

    // One clocked step on configuration k; every other configuration sits idle.
    task automatic cyc(input int k, input string tag, input bit w, input int wa, input logic [31:0] wd,
                       input bit re, input int ra, input int r0, input int r1, input int r2, input int r3);
        crd = '{r0, r1, r2, r3};
        for (int j = 0; j < 3; j++) if (j != k) drive(j, 1'b0, 0, '0, 1'b0, 0);
        cw = w; cwa = wa; cwd = wd & wmask[k]; cre = re; cra = ra;
        drive(k, cw, cwa, cwd, cre, cra);
        #1;
        check_now(k, tag);
        m_step(k);
        @(posedge clk);
        #1;
        cw = 1'b0; cre = 1'b0;
        drive(k, 1'b0, 0, '0, 1'b0, 0);
    endtask

    function automatic int rnd_addr(int k);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, nregs[k] - 1));
        return int'($urandom_range(0, (nregs[k] > 8) ? 9 : nregs[k] - 1));
    endfunction

    initial begin
        rst = 1'b1;
        cw = 1'b0; cre = 1'b0; cwa = 0; cra = 0; cwd = '0;
        crd = '{0, 1, 2, 3};
        for (int j = 0; j < 3; j++) drive(j, 1'b0, 0, '0, 1'b0, 0);
        model_reset();
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_now(k, "reset");

        // Zero register: writes and reservations to r0 vanish where r0 is hardwired.
        cyc(0, "t5 r0", 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, 0, 0);
        chk("t5 r0 data", o_data(0, 1), 32'h0);
        chk("t5 r0 busy", o_busy(0, 0), 32'h0);
        chk("t5 r0 pend", o_pend(0), 32'h0);
        chk("t5 r0 err", o_err(0), 32'h0);
        cyc(1, "t5 r0 nobyp", 1'b1, 0, 32'h1234_5678, 1'b1, 0, 0, 0, 0, 0);
        chk("t5 r0 nobyp err", o_err(1), 32'h0);
        cyc(2, "t5 r0 real", 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 0, 0);
        chk("t5 r0 real data", o_data(2, 3), 32'hFF);

        // Reserve, stall, writeback with bypass.
        cyc(0, "t2 rsv", 1'b0, 0, 0, 1'b1, 3, 3, 1, 0, 0);
        chk("t2 busy", o_busy(0, 0), 32'h1);
        chk("t2 pend1", o_pend(0), 32'h1);
        cyc(0, "t2 wb", 1'b1, 3, 32'h1234, 1'b0, 0, 3, 3, 0, 0);
        chk("t2 pend0", o_pend(0), 32'h0);
        chk("t2 data", o_data(0, 1), 32'h1234);

        // Double reservation is an error and the flag sticks.
        cyc(0, "t3 rsv1", 1'b0, 0, 0, 1'b1, 7, 7, 7, 0, 0);
        cyc(0, "t3 rsv2", 1'b0, 0, 0, 1'b1, 7, 7, 7, 0, 0);
        chk("t3 err", o_err(0), 32'h1);
        chk("t3 pend", o_pend(0), 32'h1);
        cyc(0, "t3 wb", 1'b1, 7, 32'hAA, 1'b0, 0, 7, 7, 0, 0);
        chk("t3 pend0", o_pend(0), 32'h0);
        chk("t3 err sticky", o_err(0), 32'h1);

        // Same-cycle write and reserve of one register, with and without bypass.
        cyc(0, "t4 rsv", 1'b0, 0, 0, 1'b1, 9, 9, 9, 0, 0);
        cyc(0, "t4 wr+rsv", 1'b1, 9, 32'h9999, 1'b1, 9, 9, 9, 0, 0);
        chk("t4 data", o_data(0, 0), 32'h9999);
        chk("t4 busy", o_busy(0, 1), 32'h1);
        chk("t4 pend", o_pend(0), 32'h1);
        cyc(1, "t4b rsv", 1'b0, 0, 0, 1'b1, 9, 9, 9, 0, 0);
        cyc(1, "t4b wr+rsv", 1'b1, 9, 32'h5555, 1'b1, 9, 9, 9, 0, 0);
        chk("t4b err", o_err(1), 32'h1);
        chk("t4b busy", o_busy(1, 0), 32'h0);
        chk("t4b data", o_data(1, 1), 32'h5555);
        chk("t4b pend", o_pend(1), 32'h0);

        // Asynchronous reset between clock edges.
        cyc(0, "t1 wr", 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 5, 9, 0, 0);
        chk("t1 pre data", o_data(0, 0), 32'hDEAD_BEEF);
        #2 rst = 1'b1;
        #1;
        chk("t1 data", o_data(0, 0), 32'h0);
        chk("t1 busy r9", o_busy(0, 1), 32'h0);
        chk("t1 pend", o_pend(0), 32'h0);
        chk("t1 err", o_err(0), 32'h0);
        chk("t1 err nobyp", o_err(1), 32'h0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_now(k, "t1 after");

        // Small config: fill, reserve everything, read shared and distinct addresses.
        for (int i = 0; i < 8; i++) cyc(2, "t6 fill", 1'b1, i, 32'(i * 'h11), 1'b0, 0, i, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(2, "t6 rsv", 1'b0, 0, 0, 1'b1, i, i, 0, 0, 0);
        chk("t6 pend", o_pend(2), 32'd8);
        cyc(2, "t6 read", 1'b0, 0, 0, 1'b0, 0, 2, 5, 5, 7);
        chk("t6 d0", o_data(2, 0), 32'h22);
        chk("t6 d1", o_data(2, 1), 32'h55);
        chk("t6 d2", o_data(2, 2), 32'h55);
        chk("t6 d3", o_data(2, 3), 32'h77);
        for (int p = 0; p < 4; p++) chk($sformatf("t6 busy%0d", p), o_busy(2, p), 32'h1);

        // Random traffic per configuration.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 300; n++) begin
                cyc(k, "rnd", $urandom_range(0, 1) == 1, rnd_addr(k), $urandom,
                    $urandom_range(0, 4) < 2, rnd_addr(k),
                    rnd_addr(k), rnd_addr(k), rnd_addr(k), rnd_addr(k));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
